// File: rtl/idct_1d_serial.sv
// 8-point 1D inverse DCT: one coefficient per cycle is multiplied into all eight
// accumulators over 8 cycles, then rounded, level-shifted and clamped to 8-bit pixels.
module idct_1d_serial #(
    parameter int OFFSET = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [95:0] coef_in,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [63:0] pix_out,
    output logic        out_valid,
    input  logic        out_ready
);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e             state_q, state_d;
    logic        [2:0]  k_q, k_d;
    logic        [95:0] coef_q, coef_d;
    logic        [63:0] pix_q, pix_d;
    logic signed [23:0] acc_q [8];
    logic signed [23:0] acc_d [8];

    logic signed [11:0] x_k;
    logic signed [7:0]  w   [8];
    logic signed [19:0] prod[8];
    logic signed [23:0] sum [8];
    logic               accept;

    // Q1.7 cosine magnitudes c1..c7
    function automatic logic signed [7:0] cmag(input int r);
        case (r)
            1:       return 8'sh3F;
            2:       return 8'sh3B;
            3:       return 8'sh35;
            4:       return 8'sh2D;
            5:       return 8'sh24;
            6:       return 8'sh18;
            7:       return 8'sh0C;
            default: return 8'sh00;
        endcase
    endfunction

    // cos((2n+1)k*pi/16) folded into the first half-period; r is never 0, 8 or 16
    function automatic logic signed [7:0] weight(input int n, input logic [2:0] k);
        int q;
        int r;
        if (k == 3'd0) return 8'sh2D;
        q = ((2 * n + 1) * int'(k)) % 32;
        r = (q <= 16) ? q : 32 - q;
        if (r < 8) return cmag(r);
        return -cmag(16 - r);
    endfunction

    function automatic logic [7:0] to_pixel(input logic signed [23:0] a);
        logic signed [24:0] rnd;
        int                 y;
        rnd = 25'(a) + 25'sd64;
        y   = int'(rnd >>> 7) + OFFSET;
        if (y < 0) return 8'd0;
        if (y > 255) return 8'd255;
        return 8'(y);
    endfunction

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (in_valid) state_d = StCalc;
            StCalc: if (k_q == 3'd7) state_d = StDone;
            StDone: if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decode straight from the state register, so no input reaches them combinationally
    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        pix_out   = pix_q;
    end

    assign accept = (state_q == StIdle) && in_valid;

    always_comb begin
        x_k = '0;
        for (int j = 0; j < 8; j++) begin
            if (k_q == 3'(j)) x_k = coef_q[95 - 12 * j -: 12];
        end
        for (int i = 0; i < 8; i++) begin
            w[i]    = weight(i, k_q);
            prod[i] = 20'(x_k) * 20'(w[i]);
            sum[i]  = acc_q[i] + 24'(prod[i]);
        end

        k_d    = k_q;
        coef_d = coef_q;
        pix_d  = pix_q;
        acc_d  = acc_q;
        if (accept) begin
            coef_d = coef_in;
            k_d    = 3'd0;
            for (int i = 0; i < 8; i++) acc_d[i] = '0;
        end else if (state_q == StCalc) begin
            acc_d = sum;
            k_d   = k_q + 3'd1;
            if (k_q == 3'd7) begin
                for (int i = 0; i < 8; i++) pix_d[63 - 8 * i -: 8] = to_pixel(sum[i]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_q    <= '0;
            coef_q <= '0;
            pix_q  <= '0;
            for (int i = 0; i < 8; i++) acc_q[i] <= '0;
        end else begin
            k_q    <= k_d;
            coef_q <= coef_d;
            pix_q  <= pix_d;
            for (int i = 0; i < 8; i++) acc_q[i] <= acc_d[i];
        end
    end

endmodule

// File: tb/tb_idct_1d_serial.sv
// Bench for idct_1d_serial: directed and random vectors against an arithmetic IDCT model,
// with a second instance at OFFSET=128 running in lockstep.
module tb_idct_1d_serial;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [95:0] coef_in = '0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        in_ready, out_valid, in_ready_off, out_valid_off;
    logic [63:0] pix_out, pix_out_off;

    int tests = 0;
    int fails = 0;
    int cs[8] = '{0, 63, 59, 53, 45, 36, 24, 12};

    idct_1d_serial #(.OFFSET(0)) u_dut (
        .clk(clk), .rst(rst), .coef_in(coef_in), .in_valid(in_valid), .in_ready(in_ready),
        .pix_out(pix_out), .out_valid(out_valid), .out_ready(out_ready)
    );

    idct_1d_serial #(.OFFSET(128)) u_dut_off (
        .clk(clk), .rst(rst), .coef_in(coef_in), .in_valid(in_valid), .in_ready(in_ready_off),
        .pix_out(pix_out_off), .out_valid(out_valid_off), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (observed timeout, required finish)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    function automatic int wt(input int n, input int k);
        int q;
        int r;
        if (k == 0) return cs[4];
        q = ((2 * n + 1) * k) % 32;
        r = (q <= 16) ? q : 32 - q;
        return (r < 8) ? cs[r] : -cs[16 - r];
    endfunction

    function automatic logic [63:0] model(input logic [95:0] c, input int off);
        logic [63:0] p;
        logic [11:0] f;
        int          x[8];
        int          acc;
        int          y;
        for (int k = 0; k < 8; k++) begin
            f    = c[95 - 12 * k -: 12];
            x[k] = int'($signed(f));
        end
        p = '0;
        for (int n = 0; n < 8; n++) begin
            acc = 0;
            for (int k = 0; k < 8; k++) acc += x[k] * wt(n, k);
            y = ((acc + 64) >>> 7) + off;
            if (y < 0) y = 0;
            if (y > 255) y = 255;
            p[63 - 8 * n -: 8] = 8'(y);
        end
        return p;
    endfunction

    function automatic logic [95:0] vec2(input int x0, input int x1);
        return {12'(x0), 12'(x1), 72'd0};
    endfunction

    // One full transaction; in_valid stays high with junk after the accept to show it is ignored.
    task automatic run_vec(input string tag, input logic [95:0] v, input int hold,
                           input bit direct, input logic [63:0] d0, input logic [63:0] d1);
        logic [63:0] exp0, exp1;
        int          lat;
        exp0 = model(v, 0);
        exp1 = model(v, 128);
        lat  = 0;
        while (!in_ready && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        @(negedge clk);
        coef_in  = v;
        in_valid = 1'b1;
        check({tag, "_in_ready_pre"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        coef_in = {$urandom, $urandom, $urandom};
        check({tag, "_in_ready_busy"}, 64'(in_ready), 64'd0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'd8);
        check({tag, "_pix"}, pix_out, exp0);
        check({tag, "_pix_off"}, pix_out_off, exp1);
        check({tag, "_valid_off"}, 64'(out_valid_off), 64'd1);
        if (direct) begin
            check({tag, "_pix_const"}, pix_out, d0);
            check({tag, "_pix_off_const"}, pix_out_off, d1);
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            coef_in = {$urandom, $urandom, $urandom};
            check({tag, "_hold_pix"}, pix_out, exp0);
            check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
            check({tag, "_hold_ready"}, 64'(in_ready), 64'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check({tag, "_done_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_done_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        #1 rst = 1'b1;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_pix", pix_out, 64'd0);
        check("rst_pix_off", pix_out_off, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_vec("dc", vec2(181, 0), 0, 1'b1, 64'h4040404040404040, 64'hC0C0C0C0C0C0C0C0);
        run_vec("dc_x1", vec2(181, 128), 0, 1'b1, 64'h7F75644C341C0B01, model(vec2(181, 128), 128));
        run_vec("sat_hi", vec2(2047, 0), 0, 1'b1, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF);
        run_vec("sat_lo", vec2(-200, 0), 0, 1'b1, 64'h0000000000000000, 64'h3A3A3A3A3A3A3A3A);
        run_vec("zero", 96'd0, 0, 1'b1, 64'h0000000000000000, 64'h8080808080808080);
        run_vec("bp", vec2(181, 128), 10, 1'b1, 64'h7F75644C341C0B01, model(vec2(181, 128), 128));

        // Asynchronous reset in the middle of a calculation
        @(negedge clk);
        coef_in  = vec2(500, -300);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        check("mid_rst_pix", pix_out, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_vec("post_rst", vec2(181, 0), 0, 1'b1, 64'h4040404040404040, 64'hC0C0C0C0C0C0C0C0);

        for (int i = 0; i < 25; i++) begin
            run_vec("rand", {$urandom, $urandom, $urandom}, int'($urandom_range(0, 3)),
                    1'b0, 64'd0, 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
